// File: rtl/diff_seq_pkg.sv
// Shared mode encodings, FSM state type and the per-channel next-pattern rule
// for the differential output sequencer.
package diff_seq_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;
  localparam logic [1:0] MODE_WALK   = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF    = MODE_OFF,
    ST_STATIC = MODE_STATIC,
    ST_TOGGLE = MODE_TOGGLE,
    ST_WALK   = MODE_WALK
  } state_t;

  // One output bit for the next cycle. sel marks the channel under the walk
  // pointer; with cur=0 and tick=0 this also yields each mode's initial pattern.
  function automatic logic next_bit(input logic [1:0] mode,
                                    input logic       cur,
                                    input logic       data,
                                    input logic       sel,
                                    input logic       tick);
    logic nb;
    nb = 1'b0;
    case (mode)
      MODE_STATIC: nb = data;
      MODE_TOGGLE: nb = tick ? (cur ^ data) : cur;
      MODE_WALK:   nb = sel & ~data;
      default:     nb = 1'b0;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bit debounce counter for raw board switches.
module sw_debounce #(
  parameter int WIDTH    = 1,
  parameter int DEB_W    = 16,
  parameter int DEBOUNCE = 50_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

  if ((DEBOUNCE < 1) || (longint'(DEBOUNCE - 1) >= (longint'(1) << DEB_W))) begin : g_deb_range
    $error("sw_debounce: DEBOUNCE-1 does not fit in DEB_W bits");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [DEB_W-1:0] cnt [WIDTH];

  // A bit is accepted only after its synced value has differed from the
  // accepted value for DEBOUNCE consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/diff_out_sequencer.sv
// Pattern sequencer feeding OBUFDS .I pins: debounced mode/data switches,
// free-running prescaler tick, and an OFF/STATIC/TOGGLE/WALK pattern FSM.
//
// state     | meaning
// ST_OFF    | all outputs low
// ST_STATIC | outputs follow debounced data
// ST_TOGGLE | enabled channels invert on every tick
// ST_WALK   | one-hot walks on every tick, data bits mask channels
module diff_out_sequencer #(
  parameter int N_CHAN   = 2,
  parameter int PRESC_W  = 24,
  parameter int PRESCALE = 10_000_000,
  parameter int DEB_W    = 16,
  parameter int DEBOUNCE = 50_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_i,
  input  logic [N_CHAN-1:0] data_i,
  output logic [N_CHAN-1:0] buf_i,
  output logic              tick_o,
  output logic [1:0]        mode_o
);

  import diff_seq_pkg::*;

  localparam int PTR_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(N_CHAN - 1);

  if ((PRESCALE < 2) || (longint'(PRESCALE - 1) >= (longint'(1) << PRESC_W))) begin : g_presc_range
    $error("diff_out_sequencer: PRESCALE-1 does not fit in PRESC_W bits");
  end
  if (N_CHAN < 1) begin : g_chan_range
    $error("diff_out_sequencer: N_CHAN must be at least 1");
  end

  logic [1:0]         deb_mode;
  logic [N_CHAN-1:0]  deb_data;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [N_CHAN-1:0]  buf_next;
  logic               commit;

  sw_debounce #(.WIDTH(2), .DEB_W(DEB_W), .DEBOUNCE(DEBOUNCE)) u_deb_mode (
    .clk    (clk),
    .rst    (rst),
    .raw    (mode_i),
    .stable (deb_mode)
  );

  sw_debounce #(.WIDTH(N_CHAN), .DEB_W(DEB_W), .DEBOUNCE(DEBOUNCE)) u_deb_data (
    .clk    (clk),
    .rst    (rst),
    .raw    (data_i),
    .stable (deb_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick   = (presc == PRESC_LAST);
  assign tick_o = tick;
  assign mode_o = state;

  // STATIC is entered immediately; every other mode waits for a tick. A commit
  // replaces the pattern outright, so it never also advances on that tick.
  always_comb begin
    commit   = (deb_mode != state) && ((deb_mode == MODE_STATIC) || tick);
    ptr_next = ptr;
    if (commit) begin
      ptr_next = '0;
    end else if ((state == ST_WALK) && tick) begin
      ptr_next = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
    buf_next = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      if (commit) begin
        buf_next[k] = next_bit(deb_mode, 1'b0, deb_data[k], (k == 0), 1'b0);
      end else begin
        buf_next[k] = next_bit(state, buf_i[k], deb_data[k], (ptr_next == PTR_W'(k)), tick);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
      ptr   <= '0;
      buf_i <= '0;
    end else begin
      ptr   <= ptr_next;
      buf_i <= buf_next;
      if (commit) state <= state_t'(deb_mode);
    end
  end

endmodule

// File: tb/tb_diff_out_sequencer.sv
// Directed bench for diff_out_sequencer with PRESCALE=4, DEBOUNCE=3, N_CHAN=2.
module tb_diff_out_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode_i = 2'd0;
  logic [1:0] data_i = 2'd0;
  logic [1:0] buf_i;
  logic       tick_o;
  logic [1:0] mode_o;

  int tests  = 0;
  int errors = 0;

  // Reference prescaler phase: a tick is expected whenever this reads 3.
  logic [1:0] presc_m = 2'd0;

  diff_out_sequencer #(
    .N_CHAN(2), .PRESC_W(4), .PRESCALE(4), .DEB_W(4), .DEBOUNCE(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mode_i (mode_i),
    .data_i (data_i),
    .buf_i  (buf_i),
    .tick_o (tick_o),
    .mode_o (mode_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) presc_m <= 2'd0;
    else     presc_m <= presc_m + 2'd1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the negedge after the next tick edge.
  task automatic tick_step(input string name);
    int n;
    n = 0;
    while (presc_m != 2'd3 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (presc_m != 2'd3) begin
      tests++;
      errors++;
      $display("FAIL %s_tick_wait: no tick within 8 cycles", name);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode_i = 2'd3; data_i = 2'b11;
    step(3);
    tests++; if (buf_i !== 2'b00) begin errors++; $display("FAIL reset_buf: got %b want 00", buf_i); end
    tests++; if (mode_o !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", mode_o); end
    tests++; if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick_o); end
    rst = 1'b0; mode_i = 2'd0; data_i = 2'b00;
    step(2);
    tests++; if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick_early: got %b want 0", tick_o); end
    step(1);
    tests++; if (tick_o !== 1'b1) begin errors++; $display("FAIL reset_first_tick: got %b want 1", tick_o); end
    step(1);
    tests++; if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick_pulse: got %b want 0", tick_o); end
    tests++; if (mode_o !== 2'd0) begin errors++; $display("FAIL reset_mode_hold: got %0d want 0", mode_o); end
  endtask

  task automatic test_static();
    mode_i = 2'd1; data_i = 2'b01;
    step(5);
    tests++; if (mode_o !== 2'd0) begin errors++; $display("FAIL static_not_yet: got %0d want 0", mode_o); end
    step(1);
    tests++; if (mode_o !== 2'd1) begin errors++; $display("FAIL static_mode: got %0d want 1", mode_o); end
    tests++; if (buf_i !== 2'b01) begin errors++; $display("FAIL static_buf: got %b want 01", buf_i); end
    data_i = 2'b10;
    step(2);
    data_i = 2'b01;
    step(1);
    tests++; if (buf_i !== 2'b01) begin errors++; $display("FAIL static_glitch_mid: got %b want 01", buf_i); end
    step(6);
    tests++; if (buf_i !== 2'b01) begin errors++; $display("FAIL static_glitch: got %b want 01", buf_i); end
    data_i = 2'b11;
    step(5);
    tests++; if (buf_i !== 2'b01) begin errors++; $display("FAIL static_latency: got %b want 01", buf_i); end
    step(1);
    tests++; if (buf_i !== 2'b11) begin errors++; $display("FAIL static_follow: got %b want 11", buf_i); end
  endtask

  task automatic test_toggle();
    mode_i = 2'd2; data_i = 2'b11;
    step(5);
    tests++; if (mode_o !== 2'd1) begin errors++; $display("FAIL toggle_wait_tick: got %0d want 1", mode_o); end
    tick_step("toggle_commit");
    tests++; if (mode_o !== 2'd2) begin errors++; $display("FAIL toggle_mode: got %0d want 2", mode_o); end
    tests++; if (buf_i !== 2'b00) begin errors++; $display("FAIL toggle_init: got %b want 00", buf_i); end
    tick_step("toggle_t1");
    tests++; if (buf_i !== 2'b11) begin errors++; $display("FAIL toggle_t1: got %b want 11", buf_i); end
    tick_step("toggle_t2");
    tests++; if (buf_i !== 2'b00) begin errors++; $display("FAIL toggle_t2: got %b want 00", buf_i); end
    data_i = 2'b01;
    step(4);
    tests++; if (buf_i !== 2'b11) begin errors++; $display("FAIL toggle_t3: got %b want 11", buf_i); end
    tick_step("toggle_f1");
    tests++; if (buf_i !== 2'b10) begin errors++; $display("FAIL toggle_freeze1: got %b want 10", buf_i); end
    tick_step("toggle_f2");
    tests++; if (buf_i !== 2'b11) begin errors++; $display("FAIL toggle_freeze2: got %b want 11", buf_i); end
    tick_step("toggle_f3");
    tests++; if (buf_i !== 2'b10) begin errors++; $display("FAIL toggle_freeze3: got %b want 10", buf_i); end
  endtask

  task automatic test_walk();
    mode_i = 2'd3; data_i = 2'b00;
    step(5);
    tests++; if (mode_o !== 2'd2) begin errors++; $display("FAIL walk_wait_tick: got %0d want 2", mode_o); end
    tick_step("walk_commit");
    tests++; if (mode_o !== 2'd3) begin errors++; $display("FAIL walk_mode: got %0d want 3", mode_o); end
    tests++; if (buf_i !== 2'b01) begin errors++; $display("FAIL walk_init: got %b want 01", buf_i); end
    tick_step("walk_w1");
    tests++; if (buf_i !== 2'b10) begin errors++; $display("FAIL walk_w1: got %b want 10", buf_i); end
    tick_step("walk_w2");
    tests++; if (buf_i !== 2'b01) begin errors++; $display("FAIL walk_wrap: got %b want 01", buf_i); end
    data_i = 2'b01;
    step(4);
    tests++; if (buf_i !== 2'b10) begin errors++; $display("FAIL walk_m0: got %b want 10", buf_i); end
    tick_step("walk_m1");
    tests++; if (buf_i !== 2'b00) begin errors++; $display("FAIL walk_mask1: got %b want 00", buf_i); end
    tick_step("walk_m2");
    tests++; if (buf_i !== 2'b10) begin errors++; $display("FAIL walk_mask2: got %b want 10", buf_i); end
    tick_step("walk_m3");
    tests++; if (buf_i !== 2'b00) begin errors++; $display("FAIL walk_mask3: got %b want 00", buf_i); end
  endtask

  task automatic test_mode_on_tick();
    data_i = 2'b00;
    step(8);
    tests++; if (buf_i !== 2'b01) begin errors++; $display("FAIL tick_pre_walk: got %b want 01", buf_i); end
    mode_i = 2'd2; data_i = 2'b11;
    step(5);
    tests++; if (mode_o !== 2'd3) begin errors++; $display("FAIL tick_pre_mode: got %0d want 3", mode_o); end
    tick_step("tick_commit");
    tests++; if (mode_o !== 2'd2) begin errors++; $display("FAIL tick_commit_mode: got %0d want 2", mode_o); end
    tests++; if (buf_i !== 2'b00) begin errors++; $display("FAIL tick_commit_buf: got %b want 00", buf_i); end
    tick_step("tick_after");
    tests++; if (buf_i !== 2'b11) begin errors++; $display("FAIL tick_after: got %b want 11", buf_i); end
  endtask

  task automatic test_off();
    mode_i = 2'd0;
    step(4);
    tests++; if (buf_i !== 2'b00) begin errors++; $display("FAIL off_pre_toggle: got %b want 00", buf_i); end
    step(3);
    tests++; if (mode_o !== 2'd2) begin errors++; $display("FAIL off_wait_tick: got %0d want 2", mode_o); end
    step(1);
    tests++; if (mode_o !== 2'd0) begin errors++; $display("FAIL off_mode: got %0d want 0", mode_o); end
    tests++; if (buf_i !== 2'b00) begin errors++; $display("FAIL off_buf: got %b want 00", buf_i); end
  endtask

  task automatic test_rst_mid_walk();
    mode_i = 2'd3; data_i = 2'b00;
    step(8);
    tests++; if (buf_i !== 2'b01) begin errors++; $display("FAIL rstmid_walk: got %b want 01", buf_i); end
    step(2);
    rst = 1'b1;
    step(1);
    tests++; if (buf_i !== 2'b00) begin errors++; $display("FAIL rstmid_buf: got %b want 00", buf_i); end
    tests++; if (mode_o !== 2'd0) begin errors++; $display("FAIL rstmid_mode: got %0d want 0", mode_o); end
    tests++; if (tick_o !== 1'b0) begin errors++; $display("FAIL rstmid_tick: got %b want 0", tick_o); end
    rst = 1'b0;
    step(2);
    tests++; if (tick_o !== 1'b0) begin errors++; $display("FAIL rstmid_presc_clr: got %b want 0", tick_o); end
    step(1);
    tests++; if (tick_o !== 1'b1) begin errors++; $display("FAIL rstmid_first_tick: got %b want 1", tick_o); end
  endtask

  initial begin
    test_reset();
    test_static();
    test_toggle();
    test_walk();
    test_mode_on_tick();
    test_off();
    test_rst_mid_walk();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
